ksa_pipe_adder: RTL and testbench
=================================

// Module: ksa_pipe_adder
// PURPOSE
//  Parametrised, fully pipelined Kogge-Stone adder; successor to the fixed 2-bit KSA.
//  - One clocked stage per prefix level, so one operand set can be accepted every GCLK_Pad cycle.
//  - Carry-in is folded into the prefix tree as bit position -1.
//  - A valid bit travels alongside the data, so bubbles and reset flush are explicit.
//  - Sits between the pad-level operand capture and the result pads in the arithmetic datapath.
// PARAMETERS
//  WIDTH   4                     operand/sum width in bits; legal range 2..32
//  LEVELS  $clog2(WIDTH+1)       prefix levels (derived; do not override)
//  LAT     LEVELS+2              input-to-output latency in GCLK_Pad cycles (derived)
// PORTS
//  GCLK_Pad       in   1      single clock; all state updates on its rising edge
//  RST_Pad        in   1      asynchronous, active-high reset
//  in_valid_Pad   in   1      operands on a_Pad/b_Pad/cin_Pad are valid this cycle
//  a_Pad          in   WIDTH  operand A, unsigned
//  b_Pad          in   WIDTH  operand B, unsigned
//  cin_Pad        in   1      carry-in
//  sub_Pad        in   1      subtract select; port present only with KSA_SUB_EN
//  out_valid_Pad  out  1      sum_Pad/cout_Pad carry a new result this cycle
//  sum_Pad        out  WIDTH  (A+B+cin) mod 2^WIDTH
//  cout_Pad       out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  - Reset: asserting RST_Pad clears, immediately and regardless of clock:
//    - every stage valid bit, out_valid_Pad, sum_Pad and cout_Pad (all to 0);
//    - all internal p/g registers.
//    Operations in flight at reset are discarded; none ever emerges.
//    The first capture after reset is on the first rising edge with RST_Pad low.
//  - Stage 0 (capture): on an edge with in_valid_Pad=1, register A, B and cin, then form:
//    - p[i]=A[i]^B[i], g[i]=A[i]&B[i] for bits 0..WIDTH-1;
//    - position -1 with g=cin, p=0.
//  - Stages 1..LEVELS (prefix): level k combines span 2^(k-1) using
//    G=Gh|(Ph&Gl), P=Ph&Pl. Nodes with no partner at that span pass through unchanged.
//    The original p vector is carried in a delay line alongside the tree.
//  - Stage LEVELS+1 (sum):
//    - sum[i] = p[i] ^ Gprefix[i-1], where Gprefix[-1] = cin;
//    - cout = Gprefix[WIDTH-1].
//    sum_Pad, cout_Pad and out_valid_Pad are all registered outputs.
//  - Latency: a result appears exactly LAT edges after capture.
//    Example: WIDTH=4 gives LAT=5; WIDTH=2 gives LAT=4.
//  - Throughput: 1 per cycle. Back-to-back inputs give back-to-back out_valid_Pad pulses in input order.
//  - Bubbles: in_valid_Pad=0 inserts a bubble.
//    Stage registers whose valid bit is 0 hold their previous data.
//    sum_Pad/cout_Pad hold the last valid result while out_valid_Pad=0.
//  - No backpressure and no stall: the block accepts every valid input, always.
//  - Wrap-around: results are modulo 2^WIDTH; overflow appears only as cout_Pad.
//    Maximum case: all-ones + all-ones + cin=1 gives sum all-ones, cout=1.
//  - Inputs are sampled only on rising edges; glitches or pulses between edges are ignored.
// CONFIGURATION
//  KSA_SUB_EN defined:
//   - adds the sub_Pad input;
//   - when sub_Pad=1 at capture: B is replaced by ~B and the effective cin is forced to 1
//     (cin_Pad is ignored), so the block computes A-B;
//   - cout_Pad=1 means no borrow (A>=B);
//   - sub_Pad is captured in stage 0 only; no later stage depends on it.
//  KSA_SUB_EN undefined: no sub_Pad port; the block is an adder only and its latency is identical.
// TESTING (WIDTH=4 unless noted; t counts edges after the capture edge)
//  1. Reset: RST_Pad=1 -> out_valid_Pad=0, sum_Pad=0, cout_Pad=0 with no clock edge required.
//  2. Carry chain: a=0xF, b=0x1, cin=0 -> at t=5: out_valid_Pad=1, sum=0x0, cout=1.
//  3. Back-to-back: 0x3+0x5+cin1, then 0xA+0x6+cin0 on consecutive edges
//     -> 0x9/cout0 at t=5, then 0x0/cout1 at t=6.
//  4. Bubble: valid, idle, valid -> out_valid_Pad pattern 1,0,1; sum_Pad holds during the 0.
//  5. Reset mid-flight: capture 3 operations, pulse RST_Pad at t=2 -> no out_valid_Pad for 10 cycles.
//  6. WIDTH=2: a=3, b=1, cin=1 -> at t=4: sum=1, cout=1.
//     With KSA_SUB_EN (WIDTH=4), a=3, b=5, sub=1 -> sum=0xE, cout=0.

Source files
------------

// File: rtl/ksa_pipe_adder.sv
// Fully pipelined Kogge-Stone adder: capture, p/g, one stage per prefix level, sum (latency LEVELS+2).
// Optional subtract mode is enabled by defining KSA_SUB_EN, which adds the sub_Pad input.
module ksa_pipe_adder #(
  parameter int WIDTH = 4
) (
  input  logic             GCLK_Pad,
  input  logic             RST_Pad,
  input  logic             in_valid_Pad,
  input  logic [WIDTH-1:0] a_Pad,
  input  logic [WIDTH-1:0] b_Pad,
  input  logic             cin_Pad,
`ifdef KSA_SUB_EN
  input  logic             sub_Pad,
`endif
  output logic             out_valid_Pad,
  output logic [WIDTH-1:0] sum_Pad,
  output logic             cout_Pad
);

  localparam int LEVELS = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] ALL_ONES = {(WIDTH + 1){1'b1}};

  logic             cap_v_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [WIDTH-1:0] b_d;
  logic             cin_d;

  // Tree node 0 is the carry-in (bit position -1); node i+1 is operand bit i.
  logic [WIDTH:0]   g_q  [0:LEVELS];
  logic [WIDTH:0]   p_q  [0:LEVELS];
  logic [WIDTH-1:0] pd_q [0:LEVELS];
  logic [WIDTH:0]   g_d  [0:LEVELS];
  logic [WIDTH:0]   p_d  [0:LEVELS];
  logic [WIDTH-1:0] pd_d [0:LEVELS];
  logic [LEVELS:0]  v_q;
  logic [LEVELS:0]  en_s;

  always_comb begin
    b_d   = b_Pad;
    cin_d = cin_Pad;
`ifdef KSA_SUB_EN
    if (sub_Pad) begin
      b_d   = ~b_Pad;
      cin_d = 1'b1;
    end else begin
      b_d   = b_Pad;
      cin_d = cin_Pad;
    end
`endif
  end

  always_ff @(posedge GCLK_Pad or posedge RST_Pad) begin
    if (RST_Pad) begin
      cap_v_q <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      cin_q   <= 1'b0;
    end else begin
      cap_v_q <= in_valid_Pad;
      if (in_valid_Pad) begin
        a_q   <= a_Pad;
        b_q   <= b_d;
        cin_q <= cin_d;
      end
    end
  end

  assign en_s = {v_q[LEVELS-1:0], cap_v_q};

  // Level k pairs each node with the one 2^(k-1) below it; low nodes without a partner pass through.
  always_comb begin
    g_d[0]  = {a_q & b_q, cin_q};
    p_d[0]  = {a_q ^ b_q, 1'b0};
    pd_d[0] = a_q ^ b_q;
    for (int k = 1; k <= LEVELS; k++) begin
      g_d[k]  = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << (32'd1 << (k - 1))));
      p_d[k]  = p_q[k-1] & ((p_q[k-1] << (32'd1 << (k - 1))) | ~(ALL_ONES << (32'd1 << (k - 1))));
      pd_d[k] = pd_q[k-1];
    end
  end

  always_ff @(posedge GCLK_Pad or posedge RST_Pad) begin
    if (RST_Pad) begin
      v_q <= {(LEVELS + 1){1'b0}};
      for (int k = 0; k <= LEVELS; k++) begin
        g_q[k]  <= {(WIDTH + 1){1'b0}};
        p_q[k]  <= {(WIDTH + 1){1'b0}};
        pd_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      v_q <= en_s;
      for (int k = 0; k <= LEVELS; k++) begin
        if (en_s[k]) begin
          g_q[k]  <= g_d[k];
          p_q[k]  <= p_d[k];
          pd_q[k] <= pd_d[k];
        end
      end
    end
  end

  always_ff @(posedge GCLK_Pad or posedge RST_Pad) begin
    if (RST_Pad) begin
      out_valid_Pad <= 1'b0;
      sum_Pad       <= {WIDTH{1'b0}};
      cout_Pad      <= 1'b0;
    end else begin
      out_valid_Pad <= v_q[LEVELS];
      if (v_q[LEVELS]) begin
        sum_Pad  <= pd_q[LEVELS] ^ g_q[LEVELS][WIDTH-1:0];
        cout_Pad <= g_q[LEVELS][WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Self-checking bench for ksa_pipe_adder: random traffic against an arithmetic reference model,
// plus directed carry-chain, bubble, reset and WIDTH=2 cases. Honours KSA_SUB_EN when defined.
module tb_ksa_pipe_adder;

  localparam int W   = 4;
  localparam int LAT = $clog2(W + 1) + 2;
`ifdef KSA_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin_in = 1'b0;
  logic         out_valid;
  logic [W-1:0] sum_o;
  logic         cout_o;
`ifdef KSA_SUB_EN
  logic         sub_in = 1'b0;
  logic         sub2_in = 1'b0;
`endif

  logic         v2_in = 1'b0;
  logic [1:0]   a2_in = '0;
  logic [1:0]   b2_in = '0;
  logic         c2_in = 1'b0;
  logic         ov2;
  logic [1:0]   sum2;
  logic         cout2;

  ksa_pipe_adder #(.WIDTH(W)) u_dut (
    .GCLK_Pad(clk), .RST_Pad(rst), .in_valid_Pad(in_valid),
    .a_Pad(a_in), .b_Pad(b_in), .cin_Pad(cin_in),
`ifdef KSA_SUB_EN
    .sub_Pad(sub_in),
`endif
    .out_valid_Pad(out_valid), .sum_Pad(sum_o), .cout_Pad(cout_o)
  );

  ksa_pipe_adder #(.WIDTH(2)) u_dut2 (
    .GCLK_Pad(clk), .RST_Pad(rst), .in_valid_Pad(v2_in),
    .a_Pad(a2_in), .b_Pad(b2_in), .cin_Pad(c2_in),
`ifdef KSA_SUB_EN
    .sub_Pad(sub2_in),
`endif
    .out_valid_Pad(ov2), .sum_Pad(sum2), .cout_Pad(cout2)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int           due;
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
  endtask

  task automatic check_outputs();
    logic exp_ov;
    exp_ov = (q.size() > 0) && (q[0].due == edge_n);
    check_val("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (exp_ov) begin
      last_sum  = q[0].s;
      last_cout = q[0].c;
      void'(q.pop_front());
    end
    while (q.size() > 0 && q[0].due < edge_n) void'(q.pop_front());
    check_val("sum", {28'd0, sum_o}, {28'd0, last_sum});
    check_val("cout", {31'd0, cout_o}, {31'd0, last_cout});
  endtask

  // One cycle: check outputs at the falling edge, then present the next operands.
  task automatic run_cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic s);
    exp_t e;
    int   full;
    @(negedge clk);
    check_outputs();
    in_valid = v;
    a_in     = a;
    b_in     = b;
    cin_in   = c;
`ifdef KSA_SUB_EN
    sub_in   = s;
`endif
    if (v) begin
      e.due = edge_n + 1 + LAT;
      if (s && SUB_ON) begin
        e.c = (a >= b);
        e.s = a - b;
      end else begin
        full = int'(a) + int'(b) + int'(c);
        e.s  = full[W-1:0];
        e.c  = (full >= (1 << W));
      end
      q.push_back(e);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_sum"}, {28'd0, sum_o}, 32'd0);
    check_val({tag, "_cout"}, {31'd0, cout_o}, 32'd0);
  endtask

  initial begin
    int cap2;
    #2 rst = 1'b1;
    #1;
    check_reset_values("rst0");
    check_val("rst0_ov2", {31'd0, ov2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Carry chain through every bit
    run_cycle(1'b1, 4'hF, 4'h1, 1'b0, 1'b0);
    repeat (LAT + 1) run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Back-to-back pair
    run_cycle(1'b1, 4'h3, 4'h5, 1'b1, 1'b0);
    run_cycle(1'b1, 4'hA, 4'h6, 1'b0, 1'b0);
    // Bubble between two valids
    run_cycle(1'b1, 4'h7, 4'h2, 1'b0, 1'b0);
    run_cycle(1'b0, 4'hC, 4'hC, 1'b1, 1'b0);
    run_cycle(1'b1, 4'h1, 4'h1, 1'b0, 1'b0);
    // Maximum case
    run_cycle(1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
    run_cycle(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    run_cycle(1'b1, 4'h3, 4'h5, 1'b0, 1'b1);
    run_cycle(1'b1, 4'h9, 4'h4, 1'b1, 1'b1);
    run_cycle(1'b1, 4'h6, 4'h6, 1'b0, 1'b1);
    repeat (LAT + 1) run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Random traffic with random bubbles
    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 4'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom));
    end
    repeat (LAT + 1) run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Reset mid-flight: three operations, reset two edges later, nothing may emerge
    run_cycle(1'b1, 4'h8, 4'h9, 1'b1, 1'b0);
    run_cycle(1'b1, 4'h2, 4'h3, 1'b0, 1'b0);
    run_cycle(1'b1, 4'hE, 4'h1, 1'b1, 1'b0);
    run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid");
    q.delete();
    last_sum  = '0;
    last_cout = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    // WIDTH=2 instance: 3+1+1 -> sum 1, cout 1, exactly four edges after capture
    run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    v2_in = 1'b1;
    a2_in = 2'd3;
    b2_in = 2'd1;
    c2_in = 1'b1;
    cap2  = edge_n + 1;
    run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    v2_in = 1'b0;
    a2_in = 2'd0;
    b2_in = 2'd0;
    c2_in = 1'b0;
    while (edge_n < cap2 + 3) run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    check_val("w2_ov_early", {31'd0, ov2}, 32'd0);
    run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    check_val("w2_ov", {31'd0, ov2}, 32'd1);
    check_val("w2_sum", {30'd0, sum2}, 32'd1);
    check_val("w2_cout", {31'd0, cout2}, 32'd1);
    run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    check_val("w2_ov_after", {31'd0, ov2}, 32'd0);
    check_val("w2_sum_hold", {30'd0, sum2}, 32'd1);

    // Asynchronous clear while results are held
    run_cycle(1'b1, 4'h5, 4'h6, 1'b0, 1'b0);
    repeat (LAT + 1) run_cycle(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_values("rst_async");
    check_val("rst_async_sum2", {30'd0, sum2}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
